// File: rtl/index_sequencer.sv
// Index sequencer: steps a 0..LAST_IDX lookup index either from a free-running
// prescaler tick (RUN) or from single-step requests (STOP).
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_STOP | prescaler held at 0, step rising edges advance the index
//   ST_RUN  | prescaler free-runs, index advances on every tick
module index_sequencer #(
  parameter int CLK_DIV  = 100000000,
  parameter int LAST_IDX = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  input  logic       dir,
  input  logic       clr,
  output logic [3:0] index,
  output logic       idx_valid,
  output logic       running
);

  localparam int            PW   = $clog2(CLK_DIV);
  localparam logic [PW-1:0] TC   = PW'(CLK_DIV - 1);
  localparam logic [3:0]    LAST = 4'(LAST_IDX);

  typedef enum logic {ST_STOP, ST_RUN} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [3:0]    index_nxt;
  logic          valid_nxt;
  logic          step_q;
  logic          tick;
  logic          step_edge;

  function automatic logic [3:0] advance(input logic [3:0] cur, input logic down);
    if (down) return (cur == 4'd0) ? LAST : cur - 4'd1;
    else      return (cur == LAST) ? 4'd0 : cur + 4'd1;
  endfunction

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    index_nxt = index;
    valid_nxt = 1'b0;
    tick      = (state == ST_RUN) && (presc == TC);
    step_edge = step && !step_q;

    case (state)
      ST_STOP: if (start && !stop) state_nxt = ST_RUN;
      ST_RUN:  if (stop)           state_nxt = ST_STOP;
      default:                     state_nxt = ST_STOP;
    endcase

    // clr wins over a coincident tick or step edge
    if (clr) begin
      index_nxt = 4'd0;
      valid_nxt = 1'b1;
    end else if (tick || (step_edge && state == ST_STOP)) begin
      index_nxt = advance(index, dir);
      valid_nxt = 1'b1;
    end

    // Prescaler restarts from 0 on RUN entry, on every tick and on clr.
    if (clr || tick || state != ST_RUN || state_nxt != ST_RUN)
      presc_nxt = '0;
    else
      presc_nxt = presc + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_STOP;
      presc     <= '0;
      index     <= 4'd0;
      idx_valid <= 1'b0;
      running   <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      index     <= index_nxt;
      idx_valid <= valid_nxt;
      running   <= (state_nxt == ST_RUN);
      step_q    <= step;
    end
  end

endmodule

// File: doc/index_sequencer.md
INDEX_SEQUENCER -- requirements
Module: index_sequencer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100000000, meaning clock cycles per automatic index step (legal range >= 2).
REQ-002 SHALL have parameter LAST_IDX, default 14, meaning highest index value before wrap (legal range 1..15).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, synchronous level request to enter RUN.
REQ-006 SHALL have port stop, input, 1, synchronous level request to enter STOP.
REQ-007 SHALL have port step, input, 1, synchronous single-step request; rising edge is the trigger.
REQ-008 SHALL have port dir, input, 1, count direction (0 = up, 1 = down).
REQ-009 SHALL have port clr, input, 1, synchronous index clear.
REQ-010 SHALL have port index, output, 4, current lookup index for the downstream digit-conversion stage.
REQ-011 SHALL have port idx_valid, output, 1, one-cycle pulse marking an index update.
REQ-012 SHALL have port running, output, 1, high while in RUN.

Function
REQ-013 SHALL implement a two-state FSM: STOP and RUN.
REQ-014 SHALL transition STOP->RUN when start=1 and stop=0; RUN->STOP when stop=1; stop has priority when both are high.
REQ-015 SHALL drive running as a registered output, equal to 1 exactly in the cycles the FSM is in RUN.
REQ-016 SHALL keep a prescaler counting 0..CLK_DIV-1 while in RUN, and generate an internal tick in the cycle it equals CLK_DIV-1, then return to 0.
REQ-017 SHALL hold the prescaler at 0 in STOP, so the first tick after entering RUN arrives CLK_DIV cycles after running rises.
REQ-018 SHALL advance index by one on each tick: up when dir=0 (LAST_IDX wraps to 0), down when dir=1 (0 wraps to LAST_IDX).
REQ-019 SHALL sample dir in the tick cycle itself; a change of dir between ticks has no other effect.
REQ-020 SHALL register step, and detect a rising edge as step=1 with the previous registered value 0.
REQ-021 SHALL, in STOP, advance index by one on each step rising edge under the REQ-018 direction and wrap rules, with the index updated on the next clock edge.
REQ-022 SHALL ignore step edges in RUN; holding step high produces exactly one advance.
REQ-023 SHALL, on clr=1, load index=0 and prescaler=0 on the next edge without changing FSM state; clr overrides a coincident tick or step.
REQ-024 SHALL pulse idx_valid high for exactly one cycle, registered on the same edge that updates index (tick, step or clr), including when clr reloads an index already at 0.
REQ-025 SHALL never produce an index greater than LAST_IDX.
REQ-026 SHALL, on a stop in a cycle that also has a tick, apply the tick's index advance and then enter STOP.
REQ-027 SHALL have an index-to-index latency of exactly CLK_DIV cycles in continuous RUN.

Reset
REQ-028 SHALL, while rst_n=0, immediately force: state STOP, index=0, idx_valid=0, running=0, prescaler=0, step edge register=0.
REQ-029 SHALL, after rst_n is released mid-RUN, resume in STOP; the first tick requires a fresh start followed by CLK_DIV cycles.
REQ-030 SHALL treat step held high across reset deassertion as a rising edge on the first clock after release (edge register resets to 0).

Verification (CLK_DIV=4, LAST_IDX=14)
REQ-031 SHALL cover: reset, then start pulse, dir=0 -> running=1; index 1,2,3 at 4-cycle intervals, with one idx_valid pulse per change.
REQ-032 SHALL cover: RUN up-counting through 14 -> next tick gives index=0; with dir=1 from 0 -> next tick gives index=14.
REQ-033 SHALL cover: STOP, step held high 10 cycles, then low, then high again -> index advances exactly twice, two idx_valid pulses.
REQ-034 SHALL cover: RUN with index=7, clr asserted in the same cycle as a tick -> index=0 next cycle, one idx_valid pulse, running stays 1.
REQ-035 SHALL cover: start and stop both high in STOP -> remains in STOP; stop coincident with a tick in RUN -> index advances and running=0 on the following edge.
REQ-036 SHALL cover: rst_n pulsed low asynchronously between edges mid-RUN at index=9 -> index=0, running=0 immediately; no ticks until start is asserted again.
